// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states,
// byte-enable bases and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Unsigned variants exist only for loads; halves and words must be naturally aligned.
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !off[0];
      F3_HU:   ok = !we && !off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory req/ack bus between the load/store unit (master) and memory (slave).
interface lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half from a memory word and sign- or zero-extends it.
// Purely combinational so it can be dropped into a pipelined load path as well.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] bus_rdata,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = bus_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = lane[off];
    half_sel = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    data     = bus_rdata;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Multi-cycle load/store unit: lane steering, one req/ack bus transaction with
// timeout, and a registered extended load result with a done/err pulse.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       mem_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  lsu_mem_if.master         bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic              we_reg, we_next;
  logic [2:0]        f3_reg, f3_next;
  logic [1:0]        off_reg, off_next;
  logic [31:0]       mem_data_reg, mem_data_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;
  logic              bus_req_reg, bus_req_next;
  logic              bus_we_reg, bus_we_next;
  logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
  logic [3:0]        bus_be_reg, bus_be_next;
  logic [31:0]       bus_wdata_reg, bus_wdata_next;

  logic [3:0]        store_be;
  logic [31:0]       store_wdata;
  logic [31:0]       load_data;
  logic              req_ok;

  lsu_load_align u_load_align (
    .funct3    (f3_reg),
    .off       (off_reg),
    .bus_rdata (bus.bus_rdata),
    .data      (load_data)
  );

  // Store lane steering is computed from the live inputs so it can be latched at start.
  always_comb begin
    store_be    = BE_W;
    store_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        store_be    = BE_B << addr[1:0];
        store_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        store_be    = BE_H << addr[1:0];
        store_wdata = {2{wdata[15:0]}};
      end
      default: begin
        store_be    = BE_W;
        store_wdata = wdata;
      end
    endcase
  end

  assign req_ok  = access_ok(mem_we, funct3, addr[1:0]);
  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    we_next        = we_reg;
    f3_next        = f3_reg;
    off_next       = off_reg;
    mem_data_next  = mem_data_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    busy_next      = busy_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_be_next    = bus_be_reg;
    bus_wdata_next = bus_wdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          we_next   = mem_we;
          f3_next   = funct3;
          off_next  = addr[1:0];
          busy_next = 1'b1;
          if (req_ok) begin
            bus_req_next   = 1'b1;
            bus_we_next    = mem_we;
            bus_addr_next  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_next    = mem_we ? store_be : BE_W;
            bus_wdata_next = store_wdata;
            cnt_next       = '0;
            state_next     = ST_REQ;
          end else begin
            // Illegal access: skip the bus and report straight away.
            done_next     = 1'b1;
            err_next      = 1'b1;
            mem_data_next = 32'h0;
            state_next    = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        if (bus.bus_ack) begin
          bus_req_next = 1'b0;
          if (!we_reg) mem_data_next = load_data;
          done_next    = 1'b1;
          state_next   = ST_RESP;
        end else if (cnt_inc == CNT_LIMIT) begin
          bus_req_next  = 1'b0;
          done_next     = 1'b1;
          err_next      = 1'b1;
          mem_data_next = 32'h0;
          state_next    = ST_RESP;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_RESP: begin
        busy_next  = 1'b0;
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        busy_next    = 1'b0;
        bus_req_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      f3_reg        <= 3'b000;
      off_reg       <= 2'b00;
      mem_data_reg  <= 32'h0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_be_reg    <= 4'h0;
      bus_wdata_reg <= 32'h0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      f3_reg        <= f3_next;
      off_reg       <= off_next;
      mem_data_reg  <= mem_data_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_be_reg    <= bus_be_next;
      bus_wdata_reg <= bus_wdata_next;
    end
  end

  assign mem_data      = mem_data_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign busy          = busy_reg;
  assign bus.bus_req   = bus_req_reg;
  assign bus.bus_we    = bus_we_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_be    = bus_be_reg;
  assign bus.bus_wdata = bus_wdata_reg;

endmodule
